// File: rtl/ctrl_pkg.sv
// Shared definitions for the stage-3 control code generator.
// Holds the opcode class patterns, the squash FSM state type, the
// registered control bundle and the opcode classifier helpers used by
// the decoder.
package ctrl_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } shadow_state_t;

  // Registered stage-3 control word (everything except valid/shadow_busy).
  typedef struct packed {
    logic e_r0;
    logic e_rn;
    logic xr0;
    logic sod;
    logic wr;
    logic efl;
    logic s_al;
    logic lpc;
  } ctl3_t;

  // Conditional classes, matched on opcode[7:3].
  localparam logic [4:0] COND_P0 = 5'b00001;
  localparam logic [4:0] COND_P1 = 5'b00101;
  localparam logic [4:0] COND_P2 = 5'b00110;
  localparam logic [4:0] COND_P3 = 5'b00111;
  localparam logic [4:0] COND_P4 = 5'b01001;

  // ALU-result classes: exact opcodes plus opcode[7:3] groups.
  localparam logic [7:0] ALU_OP0 = 8'h01;
  localparam logic [7:0] ALU_OP1 = 8'h02;
  localparam logic [7:0] ALU_OP2 = 8'h60;
  localparam logic [7:0] ALU_OP3 = 8'h70;
  localparam logic [4:0] ALU_P0  = 5'b00100;
  localparam logic [4:0] ALU_P1  = 5'b01000;
  localparam logic [4:0] ALU_P2  = 5'b01010;

  // Opcodes that must not enable R0: MVD group (except its base opcode)
  // and the LDA group.
  localparam logic [4:0] MVD_P    = 5'b01110;
  localparam logic [7:0] MVD_BASE = 8'h70;
  localparam logic [4:0] LDA_P    = 5'b00010;

  function automatic logic op_is_cond(input logic [7:0] op);
    logic [4:0] hi;
    hi = op[7:3];
    return (hi == COND_P0) || (hi == COND_P1) || (hi == COND_P2) ||
           (hi == COND_P3) || (hi == COND_P4);
  endfunction

  function automatic logic op_is_alu(input logic [7:0] op);
    logic [4:0] hi;
    hi = op[7:3];
    // 1000_xxxx .. 1110_xxxx: top bit set, upper nibble not all ones.
    return (op == ALU_OP0) || (op == ALU_OP1) || (op == ALU_OP2) ||
           (op == ALU_OP3) || (hi == ALU_P0) || (hi == ALU_P1) ||
           (hi == ALU_P2) || (op[7] && (op[6:4] != 3'b111));
  endfunction

  function automatic logic op_blocks_r0(input logic [7:0] op);
    return ((op[7:3] == MVD_P) && (op != MVD_BASE)) || (op[7:3] == LDA_P);
  endfunction

endpackage

// File: rtl/ctrl_code_gen3_pipe_if.sv
// Stage-2 -> stage-3 control bus of ctrl_code_gen3_pipe.
// master: the stage-2 side (drives stall/flush/valid/opcode/flags and the
//         pass-through controls, observes the stage-3 outputs).
// slave:  the stage-3 generator itself.
interface ctrl_code_gen3_pipe_if #(
  parameter int NFLAG = 8
);
  logic             stall_in;
  logic             flush_in;
  logic             valid_in;
  logic [7:0]       opcode;
  logic             e_r0_in;
  logic             e_rn_in;
  logic             xr0_in;
  logic             sod_in;
  logic             wr_in;
  logic [NFLAG-1:0] flags;

  logic             valid_out;
  logic             e_r0;
  logic             e_rn;
  logic             xr0;
  logic             sod;
  logic             wr;
  logic             efl;
  logic             s_al;
  logic             lpc;
  logic             shadow_busy;

  modport master (
    output stall_in, flush_in, valid_in, opcode, e_r0_in, e_rn_in,
           xr0_in, sod_in, wr_in, flags,
    input  valid_out, e_r0, e_rn, xr0, sod, wr, efl, s_al, lpc, shadow_busy
  );

  modport slave (
    input  stall_in, flush_in, valid_in, opcode, e_r0_in, e_rn_in,
           xr0_in, sod_in, wr_in, flags,
    output valid_out, e_r0, e_rn, xr0, sod, wr, efl, s_al, lpc, shadow_busy
  );
endinterface

// File: rtl/ctrl3_decode.sv
// Combinational stage-3 opcode decoder.
// Ports:
//   opcode      in  8      opcode from the opcode buffer
//   flags       in  NFLAG  current flag vector (indexed by opcode[2:0])
//   e_r0_block  out 1      opcode forbids enabling R0
//   efl         out 1      conditional class (enable flag / hold stage 1)
//   s_al        out 1      select ALU result to stage 4
//   cond_taken  out 1      branch loads PC (flag-qualified if RESOLVE_BR)
module ctrl3_decode
  import ctrl_pkg::*;
#(
  parameter int NFLAG      = 8,
  parameter bit RESOLVE_BR = 1'b1
) (
  input  logic [7:0]       opcode,
  input  logic [NFLAG-1:0] flags,
  output logic             e_r0_block,
  output logic             efl,
  output logic             s_al,
  output logic             cond_taken
);

  logic cond;
  logic flag_sel;

  assign cond       = op_is_cond(opcode);
  assign flag_sel   = flags[opcode[2:0]];
  assign efl        = cond;
  assign s_al       = op_is_alu(opcode);
  assign e_r0_block = op_blocks_r0(opcode);
  // Legacy mode loads the PC for every conditional class regardless of flags.
  assign cond_taken = RESOLVE_BR ? (cond & flag_sel) : cond;

endmodule

// File: rtl/ctrl_code_gen3_pipe.sv
// Stage-3 control code generator of the pipelined RISC core.
// Registers the stage-2 pass-through controls, decodes EFL/S_AL/LPC,
// resolves conditional branches against the flags and squashes the
// SHADOW_CYC valid instructions that follow a taken branch.
// Ports:
//   clk  in  system clock (rising edge)
//   rst  in  asynchronous active-high reset
//   bus  slave modport of ctrl_code_gen3_pipe_if (stall/flush/valid,
//        opcode, flags, stage-2 controls in; stage-3 controls,
//        valid_out and shadow_busy out)
module ctrl_code_gen3_pipe
  import ctrl_pkg::*;
#(
  parameter int SHADOW_CYC = 2,
  parameter int NFLAG      = 8,
  parameter bit RESOLVE_BR = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  ctrl_code_gen3_pipe_if.slave bus
);

  localparam logic [3:0] SHADOW_INIT = 4'(SHADOW_CYC);

  logic e_r0_block;
  logic efl_d;
  logic s_al_d;
  logic taken_d;

  ctrl3_decode #(
    .NFLAG      (NFLAG),
    .RESOLVE_BR (RESOLVE_BR)
  ) u_decode (
    .opcode     (bus.opcode),
    .flags      (bus.flags),
    .e_r0_block (e_r0_block),
    .efl        (efl_d),
    .s_al       (s_al_d),
    .cond_taken (taken_d)
  );

  ctl3_t         ctl_load;
  ctl3_t         ctl_p0;
  ctl3_t         ctl_nxt;
  logic          vld_p0;
  logic          vld_nxt;
  shadow_state_t state_p0;
  shadow_state_t state_nxt;
  logic [3:0]    cnt_p0;
  logic [3:0]    cnt_nxt;

  always_comb begin
    ctl_load.e_r0 = bus.e_r0_in & ~e_r0_block;
    ctl_load.e_rn = bus.e_rn_in;
    ctl_load.xr0  = bus.xr0_in;
    ctl_load.sod  = bus.sod_in;
    ctl_load.wr   = bus.wr_in;
    ctl_load.efl  = efl_d;
    ctl_load.s_al = s_al_d;
    ctl_load.lpc  = taken_d;
  end

  // Priority: flush > stall > shadow squash > normal load.
  always_comb begin
    ctl_nxt   = ctl_p0;
    vld_nxt   = vld_p0;
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    if (bus.flush_in) begin
      ctl_nxt   = '0;
      vld_nxt   = 1'b0;
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else if (!bus.stall_in) begin
      if (state_p0 == SHADOW) begin
        ctl_nxt = '0;
        vld_nxt = 1'b0;
        // Only real (valid) instructions consume the squash window.
        if (bus.valid_in && (cnt_p0 != 4'd0)) begin
          cnt_nxt = cnt_p0 - 4'd1;
          if (cnt_p0 == 4'd1) state_nxt = RUN;
        end
      end else if (bus.valid_in) begin
        ctl_nxt = ctl_load;
        vld_nxt = 1'b1;
        if (taken_d) begin
          state_nxt = SHADOW;
          cnt_nxt   = SHADOW_INIT;
        end
      end else begin
        ctl_nxt = '0;
        vld_nxt = 1'b0;
      end
    end
  end

  // Stage 2 -> stage 3 boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_p0   <= '0;
      vld_p0   <= 1'b0;
      state_p0 <= RUN;
      cnt_p0   <= '0;
    end else begin
      ctl_p0   <= ctl_nxt;
      vld_p0   <= vld_nxt;
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
    end
  end

  assign bus.valid_out   = vld_p0;
  assign bus.e_r0        = ctl_p0.e_r0;
  assign bus.e_rn        = ctl_p0.e_rn;
  assign bus.xr0         = ctl_p0.xr0;
  assign bus.sod         = ctl_p0.sod;
  assign bus.wr          = ctl_p0.wr;
  assign bus.efl         = ctl_p0.efl;
  assign bus.s_al        = ctl_p0.s_al;
  assign bus.lpc         = ctl_p0.lpc;
  assign bus.shadow_busy = (state_p0 == SHADOW);

endmodule

// File: tb/tb_ctrl_code_gen3_pipe.sv
// Bench for ctrl_code_gen3_pipe: one instance with flag-resolved branches
// and one in legacy mode, both fed the same stimulus and checked every
// cycle against a behavioural model, plus directed literal expectations.
module tb_ctrl_code_gen3_pipe;

  localparam int SHADOW_CYC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall_in = 1'b0, flush_in = 1'b0, valid_in = 1'b0;
  logic [7:0] opcode = 8'h00, flags = 8'h00;
  logic       e_r0_in = 1'b0, e_rn_in = 1'b0, xr0_in = 1'b0, sod_in = 1'b0, wr_in = 1'b0;
  bit         chk_en = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ctrl_code_gen3_pipe_if #(.NFLAG(8)) bus0 ();
  ctrl_code_gen3_pipe_if #(.NFLAG(8)) bus1 ();

  assign bus0.stall_in = stall_in;  assign bus1.stall_in = stall_in;
  assign bus0.flush_in = flush_in;  assign bus1.flush_in = flush_in;
  assign bus0.valid_in = valid_in;  assign bus1.valid_in = valid_in;
  assign bus0.opcode   = opcode;    assign bus1.opcode   = opcode;
  assign bus0.flags    = flags;     assign bus1.flags    = flags;
  assign bus0.e_r0_in  = e_r0_in;   assign bus1.e_r0_in  = e_r0_in;
  assign bus0.e_rn_in  = e_rn_in;   assign bus1.e_rn_in  = e_rn_in;
  assign bus0.xr0_in   = xr0_in;    assign bus1.xr0_in   = xr0_in;
  assign bus0.sod_in   = sod_in;    assign bus1.sod_in   = sod_in;
  assign bus0.wr_in    = wr_in;     assign bus1.wr_in    = wr_in;

  ctrl_code_gen3_pipe #(.SHADOW_CYC(SHADOW_CYC), .NFLAG(8), .RESOLVE_BR(1'b1)) dut_res (
    .clk (clk), .rst (rst), .bus (bus0.slave)
  );
  ctrl_code_gen3_pipe #(.SHADOW_CYC(SHADOW_CYC), .NFLAG(8), .RESOLVE_BR(1'b0)) dut_leg (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );

  // Output vector order: {valid, e_r0, e_rn, xr0, sod, wr, efl, s_al, lpc, shadow_busy}
  logic [9:0] outv [2];
  assign outv[0] = {bus0.valid_out, bus0.e_r0, bus0.e_rn, bus0.xr0, bus0.sod, bus0.wr,
                    bus0.efl, bus0.s_al, bus0.lpc, bus0.shadow_busy};
  assign outv[1] = {bus1.valid_out, bus1.e_r0, bus1.e_rn, bus1.xr0, bus1.sod, bus1.wr,
                    bus1.efl, bus1.s_al, bus1.lpc, bus1.shadow_busy};

  // ---------------- behavioural model ----------------
  function automatic bit m_cond(input logic [7:0] op);
    return (op >= 8'h08 && op <= 8'h0F) || (op >= 8'h28 && op <= 8'h3F) ||
           (op >= 8'h48 && op <= 8'h4F);
  endfunction

  function automatic bit m_alu(input logic [7:0] op);
    return op == 8'h01 || op == 8'h02 || op == 8'h60 || op == 8'h70 ||
           (op >= 8'h20 && op <= 8'h27) || (op >= 8'h40 && op <= 8'h47) ||
           (op >= 8'h50 && op <= 8'h57) || (op >= 8'h80 && op <= 8'hEF);
  endfunction

  function automatic bit m_kill_r0(input logic [7:0] op);
    return (op >= 8'h71 && op <= 8'h77) || (op >= 8'h10 && op <= 8'h17);
  endfunction

  // mode 0: branches resolved on flags; mode 1: legacy (every cond taken)
  function automatic bit m_taken(input int mode, input logic [7:0] op, input logic [7:0] fl);
    return m_cond(op) && (mode == 1 || fl[op[2:0]]);
  endfunction

  function automatic int m_after(input int left, input logic v);
    return v ? left - 1 : left;
  endfunction

  logic [9:0] mexp  [2];
  int         mleft [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        mexp[m]  <= '0;
        mleft[m] <= 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (flush_in) begin
          mexp[m]  <= '0;
          mleft[m] <= 0;
        end else if (stall_in) begin
          mexp[m]  <= mexp[m];
        end else if (mleft[m] != 0) begin
          mleft[m] <= m_after(mleft[m], valid_in);
          mexp[m]  <= {9'b0, m_after(mleft[m], valid_in) != 0};
        end else if (valid_in) begin
          mexp[m]  <= {1'b1, e_r0_in & ~m_kill_r0(opcode), e_rn_in, xr0_in, sod_in, wr_in,
                       m_cond(opcode), m_alu(opcode), m_taken(m, opcode, flags),
                       m_taken(m, opcode, flags)};
          mleft[m] <= m_taken(m, opcode, flags) ? SHADOW_CYC : 0;
        end else begin
          mexp[m]  <= '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (outv[m] !== mexp[m]) begin
          failures++;
          $display("FAIL model_cmp dut%0d t=%0t got=%b want=%b", m, $time, outv[m], mexp[m]);
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] op, input logic [7:0] fl,
                       input logic er0);
    valid_in = v;
    opcode   = op;
    flags    = fl;
    e_r0_in  = er0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_state", outv[0], 10'b0);

    // Taken branch, then async reset mid-cycle clears the shadow at once.
    drive(1'b1, 8'h0B, 8'h08, 1'b0);
    tick();
    chk("pre_rst_busy", {9'b0, outv[0][0]}, 10'b1);
    drive(1'b1, 8'h83, 8'h00, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_res", outv[0], 10'b0);
    chk("rst_async_leg", outv[1], 10'b0);
    rst = 1'b0;
    tick();
    chk("alu_after_rst", outv[0], 10'b1100000100);

    // MVD group blocks R0; its base opcode does not.
    drive(1'b1, 8'h72, 8'h00, 1'b1);
    tick();
    chk("mvd72", {8'b0, outv[0][8], outv[0][2]}, 10'b00);
    drive(1'b1, 8'h70, 8'h00, 1'b1);
    tick();
    chk("mvd70", {8'b0, outv[0][8], outv[0][2]}, 10'b11);

    // Resolved taken branch: two squashed instructions, third appears.
    drive(1'b1, 8'h0B, 8'h08, 1'b0);
    tick();
    chk("br_taken_c1", {7'b0, outv[0][3], outv[0][1], outv[0][0]}, 10'b111);
    drive(1'b1, 8'h80, 8'h00, 1'b0);
    tick();
    chk("br_shadow_c2", {9'b0, outv[0][9]}, 10'b0);
    tick();
    chk("br_shadow_c3", {9'b0, outv[0][9]}, 10'b0);
    tick();
    chk("br_exit_c4", {8'b0, outv[0][9], outv[0][0]}, 10'b10);

    // Not-taken under resolution; legacy instance still takes it.
    drive(1'b1, 8'h0B, 8'h00, 1'b0);
    tick();
    chk("br_nt_res", {7'b0, outv[0][3], outv[0][1], outv[0][0]}, 10'b100);
    chk("br_nt_leg", {7'b0, outv[1][3], outv[1][1], outv[1][0]}, 10'b111);
    drive(1'b1, 8'h80, 8'h00, 1'b0);
    tick();
    chk("br_nt_next", {9'b0, outv[0][9]}, 10'b1);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;

    // Stall inside the shadow freezes everything.
    drive(1'b1, 8'h0B, 8'h08, 1'b0);
    tick();
    drive(1'b1, 8'h80, 8'h00, 1'b0);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", outv[0], 10'b1000001011);
    end
    stall_in = 1'b0;
    tick();
    chk("stall_exit1", {8'b0, outv[0][9], outv[0][0]}, 10'b01);
    tick();
    chk("stall_exit2", {8'b0, outv[0][9], outv[0][0]}, 10'b00);
    tick();
    chk("stall_exit3", {8'b0, outv[0][9], outv[0][0]}, 10'b10);

    // Invalid slots do not consume the window; cond opcode cannot retrigger.
    drive(1'b1, 8'h0B, 8'h08, 1'b0);
    tick();
    drive(1'b0, 8'h80, 8'h00, 1'b0);
    tick();
    tick();
    chk("inv_no_dec", {9'b0, outv[0][0]}, 10'b1);
    drive(1'b1, 8'h0B, 8'hFF, 1'b0);
    tick();
    chk("cond_in_shadow", {7'b0, outv[0][9], outv[0][1], outv[0][0]}, 10'b001);
    tick();
    chk("cond_shadow_end", {7'b0, outv[0][9], outv[0][1], outv[0][0]}, 10'b000);
    drive(1'b1, 8'h80, 8'h00, 1'b0);
    tick();

    // Stall + flush together during shadow.
    drive(1'b1, 8'h0B, 8'h08, 1'b0);
    tick();
    stall_in = 1'b1;
    flush_in = 1'b1;
    tick();
    chk("stall_flush", outv[0], 10'b0);
    stall_in = 1'b0;
    flush_in = 1'b0;

    // Async reset while in shadow.
    tick();
    drive(1'b1, 8'h80, 8'h00, 1'b0);
    tick();
    chk("pre_rst2_busy", {9'b0, outv[0][0]}, 10'b1);
    #1 rst = 1'b1;
    #1;
    chk("rst_shadow", outv[0], 10'b0);
    #3 rst = 1'b0;
    tick();
    chk("post_rst_load", {8'b0, outv[0][9], outv[0][0]}, 10'b10);

    // Mixed traffic, checked by the model.
    for (int i = 0; i < 80; i++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      opcode   = 8'($urandom);
      flags    = 8'($urandom);
      e_r0_in  = 1'($urandom);
      e_rn_in  = 1'($urandom);
      xr0_in   = 1'($urandom);
      sod_in   = 1'($urandom);
      wr_in    = 1'($urandom);
      stall_in = ($urandom_range(0, 7) == 0);
      flush_in = ($urandom_range(0, 15) == 0);
      tick();
    end
    stall_in = 1'b0;
    flush_in = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_code_gen3_pipe.md
Name: ctrl_code_gen3_pipe

Overview:
- Parametrised successor to the stage-3 control code generator in the pipelined RISC core.
- Registers the stage-2 control pass-through (E_R0, E_RN, XR0, SOD, WR) and decodes stage-3 controls (EFL, S_AL, LPC).
- Adds valid/stall/flush handling, in-stage conditional branch resolution against the flag vector, and a branch-shadow counter that squashes the following instructions after a taken branch.

Parameters:
- SHADOW_CYC, 2, number of valid instructions squashed after a taken branch (1..15).
- NFLAG, 8, width of the flags input; flag index is opcode[2:0], so NFLAG >= 8.
- RESOLVE_BR, 1, 1 = LPC only when the selected flag is set; 0 = legacy mode, LPC for every conditional class.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- stall_in  input  1  hold stage contents
- flush_in  input  1  insert bubble, cancel shadow
- valid_in  input  1  stage-2 instruction valid
- opcode  input  8  opcode from opcode buffer
- e_r0_in  input  1  E_R0 from stage 2
- e_rn_in  input  1  E_RN from stage 2
- xr0_in  input  1  XR0 from stage 2
- sod_in  input  1  SOD from stage 2
- wr_in  input  1  WR from stage 2
- flags  input  NFLAG  current flag vector
- valid_out  output  1  stage-3 instruction valid
- e_r0  output  1  enable R0
- e_rn  output  1  enable RN
- xr0  output  1  load R0 from stage 4
- sod  output  1  select OD
- wr  output  1  write
- efl  output  1  enable flag / hold stage 1
- s_al  output  1  select ALU result to stage 4
- lpc  output  1  load PC
- shadow_busy  output  1  squash window active

Behaviour:
- Reset: every output is 0. Shadow counter is 0 and the FSM is in RUN. Reset is asynchronous; asserting it mid-shadow clears the shadow immediately.
- Latency: 1 cycle. Outputs reflect the inputs sampled at the previous rising edge.
- Per-edge priority: flush_in > stall_in > shadow squash > normal load.
- flush_in=1: load a bubble and force the FSM to RUN with counter 0. This also applies when stall_in=1 in the same cycle.
- stall_in=1 (no flush): all outputs and FSM/counter hold.
- Bubble: valid_out=0 and all control outputs 0.
- Normal load: valid_out=valid_in. If valid_in=0, load a bubble.
- Pass-through fields: e_rn, xr0, sod and wr take e_rn_in, xr0_in, sod_in and wr_in.
- e_r0 = e_r0_in AND NOT (opcode matches 0111_0xxx and opcode != 0111_0000) AND NOT (opcode matches 0001_0xxx).
- s_al=1 for:
  - 0000_0001, 0000_0010, 0110_0000, 0111_0000
  - 0010_0xxx, 0100_0xxx, 0101_0xxx
  - all opcodes 1000_xxxx through 1110_xxxx
- s_al=0 otherwise.
- Conditional classes (cond): 0000_1xxx, 0010_1xxx, 0011_0xxx, 0011_1xxx, 0100_1xxx.
- efl=cond.
- lpc=cond when RESOLVE_BR=0; lpc=cond AND flags[opcode[2:0]] when RESOLVE_BR=1.
- FSM RUN:
  - Loading a valid instruction with lpc=1 moves to SHADOW with counter=SHADOW_CYC.
  - lpc is registered for exactly that one output cycle.
- FSM SHADOW:
  - shadow_busy=1.
  - On each non-stalled edge with valid_in=1: load a bubble and decrement the counter.
  - valid_in=0 edges load a bubble without decrementing.
  - Counter reaching 0 returns to RUN; shadow_busy drops in the same edge.
  - A cond opcode arriving during SHADOW is squashed and cannot retrigger the shadow.
- Counter width is 4 bits; it never wraps below 0.
- Decode is fully specified for all 256 opcodes; unlisted patterns give efl=s_al=lpc=0.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode class constants (COND class patterns, ALU-class patterns, LDA/MVD patterns)
  - the FSM state typedef {RUN, SHADOW}
- One natural sub-module: ctrl3_decode, purely combinational. It maps opcode and flags to {e_r0_mask, efl, s_al, cond_taken}.
- The top module holds the pipeline register, the priority logic and the shadow FSM.

Test Plan:
- rst pulse mid-cycle, then opcode=1000_0011, valid_in=1, e_r0_in=1 -> before the edge, all outputs 0; after the edge, valid_out=1, e_r0=1, s_al=1, efl=0, lpc=0.
- opcode=0111_0010 with e_r0_in=1 -> e_r0=0, s_al=0. Next, opcode=0111_0000 with e_r0_in=1 -> e_r0=1, s_al=1.
- RESOLVE_BR=1, opcode=0000_1011, flags=8'h08, then three valid ALU opcodes:
  - cycle 1: efl=1, lpc=1, shadow_busy=1
  - cycles 2-3: valid_out=0
  - cycle 4: ALU instruction appears with valid_out=1, shadow_busy=0
- Same branch with flags=8'h00 -> efl=1, lpc=0, no shadow, next instruction valid. Repeat with RESOLVE_BR=0 -> lpc=1.
- Taken branch, then stall_in=1 for 3 cycles inside the shadow -> outputs and counter frozen; two unstalled valid edges are still needed to exit.
- Stall and flush together during SHADOW -> bubble, shadow_busy=0 next cycle. rst asserted asynchronously in SHADOW -> all outputs 0 without waiting for a clock edge.
